// File: rtl/rif_regbank_timer_if.sv
// rtl/rif_regbank_timer_if.sv - register-interface bundle for the timer register bank
interface rif_regbank_timer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   rif_addr;
  logic                    rif_addr_valid;
  logic                    rif_wr_req;
  logic                    rif_rd_req;
  logic [DATA_WIDTH/8-1:0] rif_wstrb;
  logic [DATA_WIDTH-1:0]   rif_wdata;
  logic [DATA_WIDTH-1:0]   rif_rdata;

  modport master (
    output rif_addr,
    output rif_wr_req,
    output rif_rd_req,
    output rif_wstrb,
    output rif_wdata,
    input  rif_addr_valid,
    input  rif_rdata
  );

  modport slave (
    input  rif_addr,
    input  rif_wr_req,
    input  rif_rd_req,
    input  rif_wstrb,
    input  rif_wdata,
    output rif_addr_valid,
    output rif_rdata
  );
endinterface

// File: rtl/rif_regbank_timer.sv
// rtl/rif_regbank_timer.sv - register bank with prescaled 32-bit timer, compare/overflow status and irq
module rif_regbank_timer #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h4144_5231
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  rif_regbank_timer_if.slave rif,
  output logic          irq
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $fatal(1, "rif_regbank_timer: DATA_WIDTH must be 32");
  end

  localparam int IDXW = ADDR_WIDTH - 2;

  localparam logic [IDXW-1:0] IDX_ID      = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_CTRL    = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_STATUS  = IDXW'(2);
  localparam logic [IDXW-1:0] IDX_CNT     = IDXW'(3);
  localparam logic [IDXW-1:0] IDX_CMP     = IDXW'(4);
  localparam logic [IDXW-1:0] IDX_SCRATCH = IDXW'(5);

  logic [IDXW-1:0] word;
  logic [31:0]     wmask;

  logic        cnt_en;
  logic        irq_en_cmp;
  logic        irq_en_ovf;
  logic [7:0]  presc;
  logic [7:0]  pcnt;
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic [31:0] scratch;
  logic        cmp_hit;
  logic        ovf;

  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_scratch;

  logic [31:0] ctrl_rd;
  logic [31:0] ctrl_nx;
  logic [31:0] cnt_inc;
  logic [31:0] cnt_nx;
  logic [7:0]  pcnt_nx;
  logic [1:0]  status_clr;
  logic        tick;
  logic        hw_cmp;
  logic        hw_ovf;
  logic        cmp_hit_nx;
  logic        ovf_nx;

  // Byte offset and read strobe carry no information for this bank.
  logic unused_ok;
  assign unused_ok = ^{rif.rif_rd_req, rif.rif_addr[1:0]};

  assign word  = rif.rif_addr[ADDR_WIDTH-1:2];
  assign wmask = {{8{rif.rif_wstrb[3]}}, {8{rif.rif_wstrb[2]}},
                  {8{rif.rif_wstrb[1]}}, {8{rif.rif_wstrb[0]}}};

  assign wr_ctrl    = rif.rif_wr_req && (word == IDX_CTRL);
  assign wr_status  = rif.rif_wr_req && (word == IDX_STATUS);
  assign wr_cnt     = rif.rif_wr_req && (word == IDX_CNT);
  assign wr_cmp     = rif.rif_wr_req && (word == IDX_CMP);
  assign wr_scratch = rif.rif_wr_req && (word == IDX_SCRATCH);

  assign ctrl_rd = {16'h0000, presc, 5'b00000, irq_en_ovf, irq_en_cmp, cnt_en};
  assign ctrl_nx = (ctrl_rd & ~wmask) | (rif.rif_wdata & wmask);

  assign tick    = cnt_en && (pcnt == presc);
  assign cnt_inc = cnt + 32'd1;

  // A CPU write to CNT in the same cycle as a tick suppresses the tick's side effects.
  assign hw_cmp = tick && !wr_cnt && (cnt_inc == cmp);
  assign hw_ovf = tick && !wr_cnt && (cnt == 32'hFFFF_FFFF);

  always_comb begin
    status_clr = 2'b00;
    if (wr_status) begin
      status_clr = rif.rif_wdata[1:0] & wmask[1:0];
    end
    // Hardware set takes priority over a simultaneous W1C.
    cmp_hit_nx = (cmp_hit & ~status_clr[0]) | hw_cmp;
    ovf_nx     = (ovf & ~status_clr[1]) | hw_ovf;
  end

  always_comb begin
    cnt_nx = cnt;
    if (wr_cnt) begin
      cnt_nx = (cnt & ~wmask) | (rif.rif_wdata & wmask);
    end else if (tick) begin
      cnt_nx = cnt_inc;
    end
  end

  always_comb begin
    pcnt_nx = pcnt + 8'd1;
    if (!cnt_en || wr_ctrl || wr_cnt || tick) begin
      pcnt_nx = 8'd0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_en     <= 1'b0;
      irq_en_cmp <= 1'b0;
      irq_en_ovf <= 1'b0;
      presc      <= 8'd0;
      pcnt       <= 8'd0;
      cnt        <= 32'd0;
      cmp        <= 32'd0;
      scratch    <= 32'd0;
      cmp_hit    <= 1'b0;
      ovf        <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        cnt_en     <= ctrl_nx[0];
        irq_en_cmp <= ctrl_nx[1];
        irq_en_ovf <= ctrl_nx[2];
        presc      <= ctrl_nx[15:8];
      end
      if (wr_cmp) begin
        cmp <= (cmp & ~wmask) | (rif.rif_wdata & wmask);
      end
      if (wr_scratch) begin
        scratch <= (scratch & ~wmask) | (rif.rif_wdata & wmask);
      end
      pcnt    <= pcnt_nx;
      cnt     <= cnt_nx;
      cmp_hit <= cmp_hit_nx;
      ovf     <= ovf_nx;
      irq     <= (cmp_hit & irq_en_cmp) | (ovf & irq_en_ovf);
    end
  end

  always_comb begin
    rif.rif_addr_valid = 1'b1;
    rif.rif_rdata      = '0;
    case (word)
      IDX_ID:      rif.rif_rdata = ID_VALUE;
      IDX_CTRL:    rif.rif_rdata = ctrl_rd;
      IDX_STATUS:  rif.rif_rdata = {30'd0, ovf, cmp_hit};
      IDX_CNT:     rif.rif_rdata = cnt;
      IDX_CMP:     rif.rif_rdata = cmp;
      IDX_SCRATCH: rif.rif_rdata = scratch;
      default:     rif.rif_addr_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rif_regbank_timer.sv
// tb/tb_rif_regbank_timer.sv - scoreboard bench for rif_regbank_timer
module tb_rif_regbank_timer;
  localparam int          AW = 12;
  localparam int          DW = 32;
  localparam logic [31:0] ID = 32'h4144_5231;

  localparam logic [11:0] A_ID      = 12'h000;
  localparam logic [11:0] A_CTRL    = 12'h004;
  localparam logic [11:0] A_STATUS  = 12'h008;
  localparam logic [11:0] A_CNT     = 12'h00C;
  localparam logic [11:0] A_CMP     = 12'h010;
  localparam logic [11:0] A_SCRATCH = 12'h014;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic irq;

  rif_regbank_timer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rif_regbank_timer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_VALUE(ID)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .rif(bus),
    .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        av;
    logic        irq;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   nread = 0;
  logic done = 1'b0;
  logic fin = 1'b0;

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic av, input logic ir);
    exp_t e;
    e.rdata = d;
    e.av    = av;
    e.irq   = ir;
    e.id    = nread;
    nread++;
    sb.push_back(e);
    bus.rif_addr   = a;
    bus.rif_rd_req = 1'b1;
    @(posedge HCLK);
    #1;
    bus.rif_rd_req = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.rif_addr   = a;
    bus.rif_wdata  = d;
    bus.rif_wstrb  = s;
    bus.rif_wr_req = 1'b1;
    @(posedge HCLK);
    #1;
    bus.rif_wr_req = 1'b0;
  endtask

  task automatic rdwr(input logic [11:0] a, input logic [31:0] d, input logic [31:0] exp_pre);
    exp_t e;
    e.rdata = exp_pre;
    e.av    = 1'b1;
    e.irq   = 1'b0;
    e.id    = nread;
    nread++;
    sb.push_back(e);
    bus.rif_addr   = a;
    bus.rif_wdata  = d;
    bus.rif_wstrb  = 4'hF;
    bus.rif_wr_req = 1'b1;
    bus.rif_rd_req = 1'b1;
    @(posedge HCLK);
    #1;
    bus.rif_wr_req = 1'b0;
    bus.rif_rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  always @(negedge HCLK) begin : monitor
    exp_t e;
    if (bus.rif_rd_req === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read addr=%h got rdata=%h with no expectation queued", bus.rif_addr, bus.rif_rdata);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.rif_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata read#%0d addr=%h got %h expected %h", e.id, bus.rif_addr, bus.rif_rdata, e.rdata);
        end
        checks++;
        if (bus.rif_addr_valid !== e.av) begin
          errors++;
          $display("FAIL addr_valid read#%0d addr=%h got %b expected %b", e.id, bus.rif_addr, bus.rif_addr_valid, e.av);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL irq read#%0d addr=%h got %b expected %b", e.id, bus.rif_addr, irq, e.irq);
        end
      end
    end
    if (done && !fin) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain %0d expectations left, expected 0", sb.size());
      end
      fin = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rif_addr   = '0;
    bus.rif_wr_req = 1'b0;
    bus.rif_rd_req = 1'b0;
    bus.rif_wstrb  = '0;
    bus.rif_wdata  = '0;
    repeat (2) @(posedge HCLK);
    #1;
    rd(A_CTRL, 32'h0, 1'b1, 1'b0);
    rd(A_CNT, 32'h0, 1'b1, 1'b0);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);
    HRESETn = 1'b1;

    // decode, byte lanes, ignored writes, read/write in the same cycle
    rd(A_ID, ID, 1'b1, 1'b0);
    rd(12'h018, 32'h0, 1'b0, 1'b0);
    rd(12'h7FC, 32'h0, 1'b0, 1'b0);
    wr(A_SCRATCH, 32'hA5A5_A5A5, 4'b1111);
    wr(A_SCRATCH, 32'h0000_00FF, 4'b0001);
    rd(A_SCRATCH, 32'hA5A5_A5FF, 1'b1, 1'b0);
    rd(12'h017, 32'hA5A5_A5FF, 1'b1, 1'b0);
    wr(A_ID, 32'hDEAD_BEEF, 4'b1111);
    rd(A_ID, ID, 1'b1, 1'b0);
    wr(A_CTRL, 32'hFFFF_FFFF, 4'b1110);
    rd(A_CTRL, 32'h0000_FF00, 1'b1, 1'b0);
    rd(A_CNT, 32'h0, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0, 4'b1111);
    rdwr(A_SCRATCH, 32'h1234_5678, 32'hA5A5_A5FF);
    rd(A_SCRATCH, 32'h1234_5678, 1'b1, 1'b0);

    // compare match with presc=3: one tick every 4 cycles
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'h0000_0303, 4'hF);
    rd(A_CNT, 32'd0, 1'b1, 1'b0);
    idle(3);
    rd(A_CNT, 32'd1, 1'b1, 1'b0);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);
    idle(13);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);
    rd(A_STATUS, 32'h1, 1'b1, 1'b0);
    rd(A_CNT, 32'd5, 1'b1, 1'b1);
    wr(A_STATUS, 32'h1, 4'hF);
    rd(A_STATUS, 32'h0, 1'b1, 1'b1);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0, 4'hF);

    // overflow with presc=0, then write-vs-tick and set-vs-clear collisions
    wr(A_CMP, 32'd3, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_CTRL, 32'h0000_0005, 4'hF);
    rd(A_CNT, 32'hFFFF_FFFE, 1'b1, 1'b0);
    rd(A_CNT, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(A_STATUS, 32'h2, 1'b1, 1'b0);
    rd(A_CNT, 32'd1, 1'b1, 1'b1);
    wr(A_CNT, 32'h0000_0100, 4'hF);
    rd(A_CNT, 32'h0000_0100, 1'b1, 1'b1);
    rd(A_STATUS, 32'h2, 1'b1, 1'b1);
    wr(A_CMP, 32'h0000_0108, 4'hF);
    idle(4);
    wr(A_STATUS, 32'h1, 4'hF);
    rd(A_STATUS, 32'h3, 1'b1, 1'b1);

    // asynchronous reset while counting with irq high
    HRESETn = 1'b0;
    rd(A_CNT, 32'h0, 1'b1, 1'b0);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);
    rd(A_CTRL, 32'h0, 1'b1, 1'b0);
    rd(A_CMP, 32'h0, 1'b1, 1'b0);
    rd(A_SCRATCH, 32'h0, 1'b1, 1'b0);
    rd(A_ID, ID, 1'b1, 1'b0);
    HRESETn = 1'b1;
    idle(6);
    rd(A_CNT, 32'h0, 1'b1, 1'b0);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);

    done = 1'b1;
    wait (fin);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
